// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_stage_pkg : shared encodings for the MEM-stage access   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mem_access_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_stage_if : valid/ack data-memory bus                    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface mem_access_stage_if #(
  parameter int ADDR_W = 32
);
  logic              dmemReq;
  logic              dmemWe;
  logic [ADDR_W-1:0] dmemAddr;
  logic [31:0]       dmemWData;
  logic [3:0]        dmemBe;
  logic [31:0]       dmemRData;
  logic              dmemAck;

  modport master (
    output dmemReq, dmemWe, dmemAddr, dmemWData, dmemBe,
    input  dmemRData, dmemAck
  );

  modport slave (
    input  dmemReq, dmemWe, dmemAddr, dmemWData, dmemBe,
    output dmemRData, dmemAck
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage_load_formatter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_formatter : lane select and sign/zero extension of load data  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module load_formatter
  import mem_access_stage_pkg::*;
(
  input  wire logic [31:0] i_rdata,
  input  wire logic [1:0]  i_addr_lo,
  input  wire logic [1:0]  i_size,
  input  wire logic        i_unsigned,
  output logic      [31:0] o_data
);

  logic [31:0] w_shift;
  assign w_shift = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_data = w_shift;
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_shift[7]}},  w_shift[7:0]};
      SZ_HALF: o_data = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
      default: o_data = w_shift;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_stage : MEM-stage data-memory access controller         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int ADDR_W         = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              memReadIn,
  input  wire logic              memWriteIn,
  input  wire logic [1:0]        sizeIn,
  input  wire logic              unsignedIn,
  input  wire logic [ADDR_W-1:0] addrIn,
  input  wire logic [31:0]       storeDataIn,
  mem_access_stage_if.master     dmem,
  output logic                   stallOut,
  output logic      [31:0]       RDOut,
  output logic                   alignErrOut,
  output logic                   busErrOut
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rd;
  logic          r_bus_err;

  logic          w_op, w_we, w_misalign, w_timeout;
  logic          w_req, w_stall, w_align;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_fmt;

  assign w_op      = memReadIn | memWriteIn;
  assign w_we      = memWriteIn & ~memReadIn;
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = storeDataIn;
    case (sizeIn)
      SZ_BYTE: begin
        w_be    = 4'b0001 << addrIn[1:0];
        w_wdata = {4{storeDataIn[7:0]}};
      end
      SZ_HALF: begin
        w_misalign = addrIn[0];
        w_be       = 4'b0011 << addrIn[1:0];
        w_wdata    = {2{storeDataIn[15:0]}};
      end
      default: w_misalign = |addrIn[1:0];
    endcase
  end

  load_formatter u_fmt (
    .i_rdata    (dmem.dmemRData),
    .i_addr_lo  (addrIn[1:0]),
    .i_size     (sizeIn),
    .i_unsigned (unsignedIn),
    .o_data     (w_fmt)
  );

  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_align = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_op) begin
          if (w_misalign) begin
            w_align = 1'b1;
          end else begin
            w_req   = 1'b1;
            w_stall = 1'b1;
            w_next  = BUSY;
          end
        end
      end
      BUSY: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (dmem.dmemAck || w_timeout) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Ack has priority over a timeout landing in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_rd      <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_op && w_misalign) r_rd  <= '0;
          else if (w_op)          r_cnt <= '0;
        end
        BUSY: begin
          if (dmem.dmemAck) begin
            if (memReadIn) r_rd <= w_fmt;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_rd      <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Reset gating keeps the bus quiet while rst is held, even with an op pending.
  assign dmem.dmemReq   = w_req & rst;
  assign dmem.dmemWe    = w_req & rst & w_we;
  assign dmem.dmemBe    = (w_req & rst) ? w_be : 4'b0000;
  assign dmem.dmemAddr  = {addrIn[ADDR_W-1:2], 2'b00};
  assign dmem.dmemWData = w_wdata;
  assign stallOut       = w_stall & rst;
  assign alignErrOut    = w_align & rst;
  assign busErrOut      = r_bus_err;
  assign RDOut          = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_access_stage : directed self-checking bench                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int TO = 4;

  logic        clk, rst;
  logic        memReadIn, memWriteIn, unsignedIn;
  logic [1:0]  sizeIn;
  logic [31:0] addrIn, storeDataIn;
  logic        stallOut, alignErrOut, busErrOut;
  logic [31:0] RDOut;

  mem_access_stage_if #(.ADDR_W(32)) bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .memReadIn   (memReadIn),
    .memWriteIn  (memWriteIn),
    .sizeIn      (sizeIn),
    .unsignedIn  (unsignedIn),
    .addrIn      (addrIn),
    .storeDataIn (storeDataIn),
    .dmem        (bus.master),
    .stallOut    (stallOut),
    .RDOut       (RDOut),
    .alignErrOut (alignErrOut),
    .busErrOut   (busErrOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          stall_n, req_n, done_f;
  logic        cap_we, cap_bus;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr, cap_wdata, cap_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ack_k: index of the request cycle carrying dmemAck (0=issue, 1=first BUSY); <0 = never
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int ack_k);
    @(negedge clk);
    memReadIn = rd; memWriteIn = wr; sizeIn = sz; unsignedIn = uns;
    addrIn = addr; storeDataIn = wdata;
    bus.dmemRData = rdata; bus.dmemAck = 1'b0;
    stall_n = 0; req_n = 0; done_f = 0;
    cap_we = 1'bx; cap_be = 'x; cap_addr = 'x; cap_wdata = 'x; cap_rd = 'x; cap_bus = 1'bx;
    for (int c = 0; c < 40 && done_f == 0; c++) begin
      #1;
      if (stallOut) stall_n++;
      if (bus.dmemReq) begin
        req_n++;
        cap_we = bus.dmemWe; cap_be = bus.dmemBe;
        cap_addr = bus.dmemAddr; cap_wdata = bus.dmemWData;
      end
      if (!stallOut) begin
        done_f = 1;
        cap_rd = RDOut; cap_bus = busErrOut;
      end else begin
        bus.dmemAck = (ack_k >= 0) && (req_n - 1 == ack_k);
        @(negedge clk);
      end
    end
    bus.dmemAck = 1'b0;
    memReadIn = 1'b0; memWriteIn = 1'b0;
    chk("access_completes", done_f, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    memReadIn = 1'b1; memWriteIn = 1'b0; sizeIn = SZ_WORD; unsignedIn = 1'b0;
    addrIn = 32'h10; storeDataIn = 32'h0;
    bus.dmemRData = 32'h0; bus.dmemAck = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req",    bus.dmemReq, 0);
    chk("rst_stall",  stallOut, 0);
    chk("rst_be",     bus.dmemBe, 0);
    chk("rst_we",     bus.dmemWe, 0);
    chk("rst_rd",     RDOut, 0);
    chk("rst_buserr", busErrOut, 0);
    chk("rst_align",  alignErrOut, 0);
    memReadIn = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // word load, ack on first BUSY cycle
    run_access(1, 0, SZ_WORD, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    chk("wl_stall", stall_n, 2);
    chk("wl_req",   req_n, 2);
    chk("wl_be",    cap_be, 4'hF);
    chk("wl_addr",  cap_addr, 32'h100);
    chk("wl_we",    cap_we, 0);
    chk("wl_rd",    cap_rd, 32'hDEADBEEF);

    // misaligned word load
    @(negedge clk);
    memReadIn = 1'b1; sizeIn = SZ_WORD; addrIn = 32'h101;
    #1;
    chk("ma_align", alignErrOut, 1);
    chk("ma_req",   bus.dmemReq, 0);
    chk("ma_stall", stallOut, 0);
    @(negedge clk);
    memReadIn = 1'b0;
    #1;
    chk("ma_rd",    RDOut, 0);
    chk("ma_pulse", alignErrOut, 0);

    // signed / unsigned byte loads at lane 3
    run_access(1, 0, SZ_BYTE, 0, 32'h103, 32'h0, 32'h80112233, 1);
    chk("sb_be",   cap_be, 4'b1000);
    chk("sb_addr", cap_addr, 32'h100);
    chk("sb_rd",   cap_rd, 32'hFFFFFF80);
    run_access(1, 0, SZ_BYTE, 1, 32'h103, 32'h0, 32'h80112233, 1);
    chk("ub_rd",   cap_rd, 32'h00000080);

    // half store, ack on 4th BUSY cycle (coincides with timeout edge)
    run_access(0, 1, SZ_HALF, 0, 32'h202, 32'h0000ABCD, 32'h0, 4);
    chk("hs_stall",  stall_n, 5);
    chk("hs_we",     cap_we, 1);
    chk("hs_addr",   cap_addr, 32'h200);
    chk("hs_be",     cap_be, 4'b1100);
    chk("hs_wdata",  cap_wdata, 32'hABCDABCD);
    chk("hs_rd",     cap_rd, 32'h00000080);
    chk("hs_buserr", cap_bus, 0);

    // signed half load, upper lane
    run_access(1, 0, SZ_HALF, 0, 32'h002, 32'h0, 32'h80011234, 2);
    chk("hl_stall", stall_n, 3);
    chk("hl_be",    cap_be, 4'b1100);
    chk("hl_rd",    cap_rd, 32'hFFFF8001);

    // read and write together: read wins
    run_access(1, 1, SZ_BYTE, 1, 32'h101, 32'h55, 32'h0000AB00, 1);
    chk("rw_we", cap_we, 0);
    chk("rw_be", cap_be, 4'b0010);
    chk("rw_rd", cap_rd, 32'h000000AB);

    // timeout: no ack
    run_access(1, 0, SZ_WORD, 0, 32'h300, 32'h0, 32'h11111111, -1);
    chk("to_req",    req_n, TO + 1);
    chk("to_stall",  stall_n, TO + 1);
    chk("to_buserr", cap_bus, 1);
    chk("to_rd",     cap_rd, 0);
    @(negedge clk);
    #1;
    chk("to_clear",  busErrOut, 0);
    chk("to_idle",   stallOut, 0);

    // reset during BUSY
    @(negedge clk);
    memReadIn = 1'b1; sizeIn = SZ_WORD; unsignedIn = 1'b0; addrIn = 32'h400;
    @(negedge clk);
    #1;
    chk("rb_busy_stall", stallOut, 1);
    chk("rb_busy_req",   bus.dmemReq, 1);
    rst = 1'b0;
    #1;
    chk("rb_req_drop",   bus.dmemReq, 0);
    chk("rb_stall_drop", stallOut, 0);
    @(negedge clk);
    memReadIn = 1'b0; bus.dmemRData = 32'hCAFEF00D; bus.dmemAck = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.dmemAck = 1'b0;
    #1;
    chk("rb_late_ack_rd", RDOut, 0);
    chk("rb_late_stall",  stallOut, 0);
    chk("rb_late_req",    bus.dmemReq, 0);
    run_access(1, 0, SZ_WORD, 0, 32'h40, 32'h0, 32'h12345678, 2);
    chk("rb_post_stall", stall_n, 3);
    chk("rb_post_rd",    cap_rd, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
